// File: rtl/core_pkg.sv
// Shared definitions for the core's load/store path: funct3 encodings for
// memory accesses and the state encoding of the data-memory port.
package core_pkg;

    localparam logic [2:0] F3_BYTE       = 3'b000;
    localparam logic [2:0] F3_HALFWORD   = 3'b001;
    localparam logic [2:0] F3_WORD       = 3'b010;
    localparam logic [2:0] F3_BYTE_U     = 3'b100;
    localparam logic [2:0] F3_HALFWORD_U = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/load_data_aligner.sv
// Picks the addressed byte or halfword out of a full bus word and extends it
// to 32 bits according to funct3. Unknown funct3 values pass the word through.
module load_data_aligner
    import core_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  f3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane selection followed by sign or zero extension.
    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (f3)
            F3_BYTE:       data = {{24{byte_lane[7]}}, byte_lane};
            F3_BYTE_U:     data = {24'h000000, byte_lane};
            F3_HALFWORD:   data = {{16{half_lane[15]}}, half_lane};
            F3_HALFWORD_U: data = {16'h0000, half_lane};
            default:       data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Data-memory port of the multi-cycle core. Runs one valid/ready request plus
// response transaction per access, stalls the core meanwhile, extends load
// data, and reports misaligned accesses and bus timeouts as one-cycle pulses.
module lsu_mem_port
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        acc_valid,
    input  logic        acc_we,
    input  logic [31:0] acc_addr,
    input  logic [2:0]  acc_f3,
    input  logic [3:0]  acc_be,
    input  logic [31:0] acc_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault_misaligned,
    output logic        fault_timeout,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt;
    logic [31:0] ext_data;
    logic        accept;
    logic        expired;

    load_data_aligner u_aligner (
        .rdata  (bus_rdata),
        .offset (off_q),
        .f3     (f3_q),
        .data   (ext_data)
    );

    assign accept  = (state == IDLE) && acc_valid && (acc_be != 4'b0000);
    assign expired = (cnt == 8'(TIMEOUT_CYCLES - 1));

    assign stall     = accept || (state == REQ) || (state == WAIT);
    assign done      = (state == DONE);
    assign bus_valid = (state == REQ);
    assign bus_addr  = bus_valid ? addr_q  : 32'h0;
    assign bus_we    = bus_valid ? we_q    : 1'b0;
    assign bus_be    = bus_valid ? be_q    : 4'b0000;
    assign bus_wdata = bus_valid ? wdata_q : 32'h0;

    // Transaction FSM, timeout counter, captured access fields and load result;
    // on the deadline cycle the timeout wins over a simultaneous handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            addr_q           <= 32'h0;
            we_q             <= 1'b0;
            be_q             <= 4'b0000;
            wdata_q          <= 32'h0;
            f3_q             <= 3'b000;
            off_q            <= 2'b00;
            cnt              <= 8'h00;
            load_data        <= 32'h0;
            fault_misaligned <= 1'b0;
            fault_timeout    <= 1'b0;
        end else begin
            fault_misaligned <= 1'b0;
            fault_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc_valid) begin
                        if (acc_be == 4'b0000) begin
                            fault_misaligned <= 1'b1;
                        end else begin
                            addr_q  <= {acc_addr[31:2], 2'b00};
                            off_q   <= acc_addr[1:0];
                            we_q    <= acc_we;
                            be_q    <= acc_be;
                            wdata_q <= acc_wdata;
                            f3_q    <= acc_f3;
                            cnt     <= 8'h00;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (expired) begin
                        fault_timeout <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (bus_ready) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (expired) begin
                        fault_timeout <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (bus_rvalid) begin
                            state <= DONE;
                            if (!we_q) begin
                                load_data <= ext_data;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: expected load results go into a
// scoreboard queue when an access is issued and are compared on done.
module tb_lsu_mem_port;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        acc_valid;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [2:0]  acc_f3;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        fault_misaligned;
    logic        fault_timeout;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_load = 32'h0;

    always #5 clk = ~clk;

    lsu_mem_port #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .acc_valid        (acc_valid),
        .acc_we           (acc_we),
        .acc_addr         (acc_addr),
        .acc_f3           (acc_f3),
        .acc_be           (acc_be),
        .acc_wdata        (acc_wdata),
        .stall            (stall),
        .done             (done),
        .load_data        (load_data),
        .fault_misaligned (fault_misaligned),
        .fault_timeout    (fault_timeout),
        .bus_valid        (bus_valid),
        .bus_ready        (bus_ready),
        .bus_addr         (bus_addr),
        .bus_we           (bus_we),
        .bus_be           (bus_be),
        .bus_wdata        (bus_wdata),
        .bus_rvalid       (bus_rvalid),
        .bus_rdata        (bus_rdata)
    );

    // Reference extension: shift the wanted lane down, then extend.
    function automatic logic [31:0] ref_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [31:0] sh;
        int          amt;
        amt = 8 * int'(off);
        sh  = word >> amt;
        case (f3)
            3'b000: return {{24{sh[7]}}, sh[7:0]};
            3'b100: return {24'h0, sh[7:0]};
            3'b001: begin
                sh = off[1] ? (word >> 16) : word;
                return {{16{sh[15]}}, sh[15:0]};
            end
            3'b101: begin
                sh = off[1] ? (word >> 16) : word;
                return {16'h0, sh[15:0]};
            end
            default: return word;
        endcase
    endfunction

    task automatic test_reset();
        rst_n      = 1'b0;
        acc_valid  = 1'b0;
        acc_we     = 1'b0;
        acc_addr   = 32'h0;
        acc_f3     = 3'b000;
        acc_be     = 4'b0000;
        acc_wdata  = 32'h0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall, done, fault_misaligned, fault_timeout, bus_valid, bus_we} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {stall, done, fault_misaligned, fault_timeout, bus_valid, bus_we});
        end
        checks++;
        if ({load_data, bus_addr, bus_wdata, bus_be} !== 100'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: load_data %h bus_addr %h bus_wdata %h bus_be %b expected all 0",
                     load_data, bus_addr, bus_wdata, bus_be);
        end
        model_load = 32'h0;
        rst_n = 1'b1;
    endtask

    // Issues one access, acts as the bus slave, and compares the scoreboard on done.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ready_wait, input logic [31:0] exp_load, input string name,
                              output int done_cyc);
        int          cyc;
        logic [31:0] exp_val;
        @(negedge clk);
        acc_valid = 1'b1;
        acc_we    = we;
        acc_addr  = addr;
        acc_f3    = f3;
        acc_be    = be;
        acc_wdata = wdata;
        exp_q.push_back(exp_load);
        cyc = 0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s stall_c0: got %b expected 1", name, stall);
        end
        for (int i = 0; i <= ready_wait; i++) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (bus_valid !== 1'b1 || bus_addr !== {addr[31:2], 2'b00} || bus_we !== we ||
                bus_be !== be || bus_wdata !== wdata) begin
                errors++;
                $display("[TB] FAIL %s req_c%0d: got v=%b a=%h we=%b be=%b wd=%h expected v=1 a=%h we=%b be=%b wd=%h",
                         name, cyc, bus_valid, bus_addr, bus_we, bus_be, bus_wdata,
                         {addr[31:2], 2'b00}, we, be, wdata);
            end
            if (i == 0) begin
                checks++;
                if (load_data !== model_load) begin
                    errors++;
                    $display("[TB] FAIL %s load_hold: got %h expected %h", name, load_data, model_load);
                end
            end
            bus_ready = (i == ready_wait);
        end
        @(negedge clk);
        cyc++;
        bus_ready = 1'b0;
        checks++;
        if (bus_valid !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s wait_state: got valid=%b stall=%b expected valid=0 stall=1",
                     name, bus_valid, stall);
        end
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        @(negedge clk);
        cyc++;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        acc_valid  = 1'b0;
        for (int k = 0; k < 8 && done !== 1'b1; k++) begin
            @(negedge clk);
            cyc++;
        end
        exp_val = exp_q.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            done_cyc = -1;
            $display("[TB] FAIL %s done_wait: got no done within budget expected done", name);
        end else begin
            done_cyc = cyc;
            if (load_data !== exp_val) begin
                errors++;
                $display("[TB] FAIL %s load_data: got %h expected %h", name, load_data, exp_val);
            end
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s stall_done: got %b expected 0", name, stall);
            end
        end
        model_load = exp_val;
    endtask

    task automatic test_lb();
        int dc;
        run_access(1'b0, 32'h0000_0103, 3'b000, 4'b1000, 32'h0, 32'h80FF_1234, 0, 32'hFFFF_FF80, "lb", dc);
        checks++;
        if (dc != 3) begin
            errors++;
            $display("[TB] FAIL lb done_cycle: got %0d expected 3", dc);
        end
    endtask

    task automatic test_lhu();
        int dc;
        run_access(1'b0, 32'h0000_0202, 3'b101, 4'b1100, 32'h0, 32'hBEEF_0001, 0, 32'h0000_BEEF, "lhu", dc);
        checks++;
        if (dc != 3) begin
            errors++;
            $display("[TB] FAIL lhu done_cycle: got %0d expected 3", dc);
        end
    endtask

    task automatic test_store_backpressure();
        int dc;
        run_access(1'b1, 32'h0000_0040, 3'b010, 4'b1111, 32'hDEAD_BEEF, 32'h5555_AAAA, 3, model_load, "sw", dc);
        checks++;
        if (dc != 6) begin
            errors++;
            $display("[TB] FAIL sw done_cycle: got %0d expected 6", dc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw done_width: got %b expected 0", done);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        acc_valid = 1'b1;
        acc_we    = 1'b0;
        acc_addr  = 32'h0000_0101;
        acc_f3    = 3'b010;
        acc_be    = 4'b0000;
        #1;
        checks++;
        if (stall !== 1'b0 || fault_misaligned !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misaligned_c0: got stall=%b fault=%b expected 0 0", stall, fault_misaligned);
        end
        @(negedge clk);
        acc_valid = 1'b0;
        checks++;
        if (fault_misaligned !== 1'b1 || bus_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misaligned_c1: got fault=%b valid=%b stall=%b expected 1 0 0",
                     fault_misaligned, bus_valid, stall);
        end
        @(negedge clk);
        checks++;
        if (fault_misaligned !== 1'b0 || bus_valid !== 1'b0 || load_data !== model_load) begin
            errors++;
            $display("[TB] FAIL misaligned_c2: got fault=%b valid=%b load=%h expected 0 0 %h",
                     fault_misaligned, bus_valid, load_data, model_load);
        end
    endtask

    task automatic test_timeout(input bit accept);
        int   fault_cyc = -1;
        int   pulses = 0;
        bit   idle_ok = 1'b0;
        bit   done_seen = 1'b0;
        bit   early_drop = 1'b0;
        @(negedge clk);
        acc_valid = 1'b1;
        acc_we    = 1'b0;
        acc_addr  = 32'h0000_0080;
        acc_f3    = 3'b010;
        acc_be    = 4'b1111;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            acc_valid = 1'b0;
            bus_ready = accept && (c == 1);
            if (fault_timeout === 1'b1) begin
                pulses++;
                if (fault_cyc < 0) begin
                    fault_cyc = c;
                    idle_ok   = (bus_valid === 1'b0) && (stall === 1'b0);
                end
            end
            if (done === 1'b1) done_seen = 1'b1;
            if (!accept && c <= TO && bus_valid !== 1'b1) early_drop = 1'b1;
        end
        bus_ready = 1'b0;
        checks++;
        if (fault_cyc != TO + 1 || pulses != 1) begin
            errors++;
            $display("[TB] FAIL timeout_%0d cycle: got cycle %0d pulses %0d expected cycle %0d pulses 1",
                     accept, fault_cyc, pulses, TO + 1);
        end
        checks++;
        if (!idle_ok || done_seen || early_drop) begin
            errors++;
            $display("[TB] FAIL timeout_%0d state: got idle_ok=%b done_seen=%b early_drop=%b expected 1 0 0",
                     accept, idle_ok, done_seen, early_drop);
        end
        checks++;
        if (load_data !== model_load) begin
            errors++;
            $display("[TB] FAIL timeout_%0d load_data: got %h expected %h", accept, load_data, model_load);
        end
    endtask

    task automatic test_reset_mid();
        bit done_seen = 1'b0;
        @(negedge clk);
        acc_valid = 1'b1;
        acc_we    = 1'b0;
        acc_addr  = 32'h0000_0300;
        acc_f3    = 3'b010;
        acc_be    = 4'b1111;
        @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        rst_n     = 1'b0;
        acc_valid = 1'b0;
        model_load = 32'h0;
        #1;
        checks++;
        if (bus_valid !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || load_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got valid=%b stall=%b done=%b load=%h expected 0 0 0 0",
                     bus_valid, stall, done, load_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1234_5678;
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1) done_seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (done_seen || load_data !== 32'h0 || bus_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_rvalid: got done_seen=%b load=%h valid=%b expected 0 0 0",
                     done_seen, load_data, bus_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3_tab[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          dc;
        for (int n = 0; n < 8; n++) begin
            f3    = f3_tab[$urandom_range(0, 4)];
            off   = 2'($urandom_range(0, 3));
            rdata = $urandom;
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3[1:0] == 2'b10) off = 2'b00;
            case (f3[1:0])
                2'b00:   be = 4'b0001 << off;
                2'b01:   be = 4'b0011 << off;
                default: be = 4'b1111;
            endcase
            addr = ($urandom & 32'hFFFF_FFFC) | {30'h0, off};
            run_access(1'b0, addr, f3, be, 32'h0, rdata, 0, ref_extend(rdata, off, f3), "b2b", dc);
            checks++;
            if (dc != 3) begin
                errors++;
                $display("[TB] FAIL b2b done_cycle: got %0d expected 3", dc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu();
        test_store_backpressure();
        test_misaligned();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Sequential data-memory port sitting directly downstream of the load/store byte-lane decoder in the multi-cycle core. It takes an already-aligned access (byte enables, lane-positioned write data, funct3), runs one valid/ready request and response transaction on the data bus, and stalls the core until the transaction completes. For loads, it extracts the addressed lanes and sign- or zero-extends them. It also reports misaligned accesses and bus timeouts as one-cycle fault pulses.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting in REQ plus WAIT before a timeout fault is raised. Range 1..255.
- clk  in  1  core clock; everything is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- acc_valid  in  1  core requests an access; sampled only in IDLE.
- acc_we  in  1  1 = store, 0 = load.
- acc_addr  in  32  byte address, as produced by the ALU.
- acc_f3  in  3  funct3 of the access (byte/half/word, with signed or unsigned variant).
- acc_be  in  4  byte enables from the decoder; 0 means misaligned.
- acc_wdata  in  32  lane-positioned store data.
- stall  out  1  core must hold its inputs and PC while this is high.
- done  out  1  one-cycle pulse when an access finishes without fault.
- load_data  out  32  extended load result; held until the next done.
- fault_misaligned  out  1  one-cycle pulse; no bus transaction is issued.
- fault_timeout  out  1  one-cycle pulse; the transaction is abandoned.
- bus_valid  out  1  request valid.
- bus_ready  in  1  request accepted.
- bus_addr  out  32  word-aligned address (acc_addr with bits [1:0] forced to 0).
- bus_we  out  1  write strobe.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  write data.
- bus_rvalid  in  1  response valid, for both loads and stores.
- bus_rdata  in  32  read data, full word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE, acc_valid=1, acc_be=0: pulse fault_misaligned the next cycle and stay in IDLE.
- IDLE, acc_valid=1, acc_be≠0: register addr, we, be, wdata, f3 and addr[1:0]; go to REQ.
- REQ: bus_valid=1 and bus_* outputs come from the registered copies.
  - bus_ready=1: go to WAIT.
  - bus_valid, once high, stays high with stable fields until bus_ready.
- WAIT: on bus_rvalid, go to DONE. For a load, capture the extended load data on that edge.
- DONE: done=1 for one cycle, then return to IDLE.
- stall = acc_valid in IDLE with nonzero be, or state being REQ or WAIT. stall is low in DONE so the core advances.
- Timeout counter:
  - Cleared on entry to REQ; increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: pulse fault_timeout, drop bus_valid, return to IDLE.
  - load_data is left unchanged.
- Load extraction, using the registered offset:
  - Byte: rdata[8*off +: 8]. Half: rdata[16*off[1] +: 16]. Word: all 32 bits.
  - The signed f3 variants sign-extend; the _U variants zero-extend.
- A bus_rvalid arriving in IDLE or REQ is ignored.
- Reset mid-transaction: return to IDLE immediately and drop bus_valid. No response is awaited afterwards.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Load or store with a zero-wait bus (ready and rvalid each on their first possible cycle): acc_valid at cycle 0, REQ at 1, WAIT at 2, DONE at 3.
- stall is high in cycles 0–2; done is high in cycle 3.
- load_data is valid from cycle 3 and stable until the next DONE.
- Misaligned access: fault pulse in cycle 1. stall stays low throughout.
- The timeout fires after exactly TIMEOUT_CYCLES cycles spent in REQ plus WAIT.

## Structure
- Shared package core_pkg holds:
  - the F3_BYTE/HALFWORD/WORD and _U constants;
  - the lsu_state_t enum {IDLE, REQ, WAIT, DONE}.
- Sub-module load_data_aligner: combinational; inputs rdata, offset and f3; output is the extended 32-bit word.

## Test plan
- LB at addr 0x103, bus_rdata=0x80FF_1234 (ready and rvalid immediate) -> load_data=0xFFFF_FF80, done in cycle 3, bus_addr=0x100, bus_be=0000 was never used.
- LHU at addr 0x202, bus_rdata=0xBEEF_0001 -> load_data=0x0000_BEEF, bus_be=1100 during REQ.
- SW at addr 0x40, wdata=0xDEAD_BEEF, bus_ready held low for 3 cycles -> bus_valid and all bus fields stable for 4 cycles; done 2 cycles after the handshake.
- Access with acc_be=0000 -> fault_misaligned pulse in cycle 1, bus_valid never asserted, stall low.
- TIMEOUT_CYCLES=8, bus_rvalid never arrives -> fault_timeout exactly 8 cycles after entering REQ, back in IDLE, load_data unchanged.
- rst_n asserted while in WAIT, then a late bus_rvalid -> outputs go to 0, state is IDLE, and the late response is ignored (no done).
